k12_nonce_scheduler: RTL

//  Sequences one K12 hash core across a nonce range: accepts a job (1600-bit state template,

---
 rtl/k12_pkg.sv | 8 +
 rtl/k12_result_slot.sv | 31 +++
 rtl/k12_nonce_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/k12_pkg.sv
// k12_pkg: shared widths, compare-window bounds and scheduler state encoding for the K12 nonce scheduler
package k12_pkg;
  localparam int K12_STATE_W = 1600;
  localparam int K12_HASH_W  = 256;
  localparam int K12_CMP_MSB = 255;
  localparam int K12_CMP_LSB = 192;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, REPORT, DRAIN} sched_state_t;
endpackage

// File: rtl/k12_result_slot.sv
// k12_result_slot: single-entry valid/ready holding register for a nonce hit
module k12_result_slot #(
  parameter int NW = 32,
  parameter int HW = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [NW-1:0] in_nonce,
  input  logic [HW-1:0] in_hash,
  input  logic          ready,
  output logic          valid,
  output logic [NW-1:0] nonce,
  output logic [HW-1:0] hash,
  output logic          full
);
  assign full = valid && !ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      nonce <= '0;
      hash  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      nonce <= in_nonce;
      hash  <= in_hash;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/k12_nonce_scheduler.sv
// k12_nonce_scheduler: walks one K12 core across a nonce range, splicing each nonce into the
// job template, comparing the hash word against the target and queuing hits to the host
module k12_nonce_scheduler
  import k12_pkg::*;
#(
  parameter int NONCE_W   = 32,
  parameter int NONCE_LSB = 312,
  parameter int TIMEOUT   = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [K12_STATE_W-1:0] job_state,
  input  logic [63:0]            job_target,
  input  logic [NONCE_W-1:0]     job_nonce_start,
  input  logic [NONCE_W-1:0]     job_nonce_count,
  input  logic                   abort,
  output logic                   core_start,
  output logic [K12_STATE_W-1:0] core_data,
  input  logic [K12_HASH_W-1:0]  core_hash,
  input  logic                   core_valid,
  output logic                   found_valid,
  input  logic                   found_ready,
  output logic [NONCE_W-1:0]     found_nonce,
  output logic [K12_HASH_W-1:0]  found_hash,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  sched_state_t state, nxt;
  logic [K12_STATE_W-1:0] tmpl, spl;
  logic [63:0] tgt;
  logic [NONCE_W-1:0] nonce, rem;
  logic [K12_HASH_W-1:0] hash_r;
  logic [CW-1:0] cnt;
  logic accept, waiting, seen, expired, hit, last, need, adv, load, slot_full, done_nxt, set_to;
  assign accept    = state == IDLE && job_valid;
  assign waiting   = state == WAIT || state == DRAIN;
  assign seen      = core_valid && cnt != '0;
  assign expired   = cnt >= T_LAST;
  assign hit       = hash_r[K12_CMP_MSB:K12_CMP_LSB] < tgt;
  assign last      = rem == NONCE_W'(1);
  // A hit lands straight from CHECK when the slot is free, so REPORT only costs cycles on back-pressure
  assign need      = state == REPORT || (state == CHECK && hit);
  assign adv       = !abort && (state == CHECK || state == REPORT) && !(need && slot_full);
  assign load      = adv && need;
  assign set_to    = waiting && !seen && expired;
  assign job_ready = state == IDLE;
  assign busy      = state != IDLE;
  always_comb begin
    spl = tmpl;
    spl[NONCE_LSB+:NONCE_W] = nonce;
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   nxt = job_valid && job_nonce_count != '0 ? ISSUE : IDLE;
      ISSUE:  nxt = abort ? IDLE : WAIT;
      WAIT, DRAIN:
        if (seen) nxt = state == DRAIN || abort ? IDLE : CHECK;
        else if (expired) nxt = IDLE;
        else if (abort) nxt = DRAIN;
      CHECK, REPORT:
        nxt = abort ? IDLE : !adv ? REPORT : last ? IDLE : ISSUE;
      default: nxt = IDLE;
    endcase
    done_nxt = (state != IDLE && nxt == IDLE) || (accept && job_nonce_count == '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tmpl        <= '0;
      tgt         <= '0;
      nonce       <= '0;
      rem         <= '0;
      hash_r      <= '0;
      cnt         <= '0;
      core_start  <= 1'b0;
      core_data   <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state      <= nxt;
      done       <= done_nxt;
      core_start <= state == ISSUE && !abort;
      if (accept) begin
        tmpl        <= job_state;
        tgt         <= job_target;
        nonce       <= job_nonce_start;
        rem         <= job_nonce_count;
        err_timeout <= 1'b0;
      end else if (set_to) begin
        err_timeout <= 1'b1;
      end
      if (state == ISSUE) begin
        core_data <= spl;
        cnt       <= '0;
      end else if (waiting) begin
        cnt <= cnt + 1'b1;
      end
      if (state == WAIT && nxt == CHECK) hash_r <= core_hash;
      if (adv) begin
        rem   <= rem - 1'b1;
        nonce <= nonce + 1'b1;
      end
    end
  end
  k12_result_slot #(.NW(NONCE_W), .HW(K12_HASH_W)) u_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .in_nonce (nonce),
    .in_hash  (hash_r),
    .ready    (found_ready),
    .valid    (found_valid),
    .nonce    (found_nonce),
    .hash     (found_hash),
    .full     (slot_full)
  );
endmodule
